// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from the icache and
// feeds {npc, instruction} into the IF/ID latch, with stall/redirect/halt handling.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic [31:0]      imemload,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic             imemREN,
  output logic [31:0]      imemaddr,
  output logic             fetch_valid,
  output logic [31:0]      fetch_npc,
  output logic [31:0]      fetch_imemload,
  output logic             doflush,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [31:0]      pc, pc_n;
  logic [31:0]      pend_pc, pend_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      pc_inc;
  logic [31:0]      target;
  logic             ren, valid, flush, stopped;

  assign pc_inc = pc + 32'd4;
  assign target = redirect_pc & 32'hFFFF_FFFC;

  // State, PC, pending target and delivery counter
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= RUN;
      pc      <= PC_INIT;
      pend_pc <= 32'd0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_n;
      cnt     <= cnt_n;
    end
  end

  // Next-state and strobe logic; priority is halt > redirect > stall > ihit
  always_comb begin
    state_n = state;
    pc_n    = pc;
    pend_n  = pend_pc;
    cnt_n   = cnt;
    ren     = 1'b0;
    valid   = 1'b0;
    flush   = 1'b0;
    stopped = 1'b0;
    case (state)
      RUN: begin
        ren = 1'b1;
        if (halt) begin
          state_n = HALTED;
        end else if (redirect) begin
          flush = 1'b1;
          if (ihit) begin
            pc_n = target;
          end else begin
            // Keep the outstanding miss addressed at pc; retarget once it lands
            pend_n  = target;
            state_n = DRAIN;
          end
        end else if (!stall && ihit) begin
          valid = 1'b1;
          pc_n  = pc_inc;
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        ren = 1'b1;
        if (halt) begin
          state_n = HALTED;
        end else begin
          if (redirect) begin
            flush  = 1'b1;
            pend_n = target;
          end
          if (ihit) begin
            pc_n    = redirect ? target : pend_pc;
            state_n = RUN;
          end
        end
      end
      HALTED: begin
        stopped = 1'b1;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  // Strobes are forced low while reset is held
  assign imemREN        = nRST & ren;
  assign fetch_valid    = nRST & valid;
  assign doflush        = nRST & flush;
  assign halted         = nRST & stopped;
  assign imemaddr       = pc;
  assign fetch_npc      = pc_inc;
  assign fetch_imemload = imemload;
  assign fetch_count    = cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a cycle model checked on every
// falling edge, plus literal expectations from the hand-worked sequence.
module tb_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam int unsigned CNT_W   = 32;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             ihit = 1'b0;
  logic [31:0]      imemload = 32'd0;
  logic             stall = 1'b0;
  logic             redirect = 1'b0;
  logic [31:0]      redirect_pc = 32'd0;
  logic             halt = 1'b0;
  logic             imemREN;
  logic [31:0]      imemaddr;
  logic             fetch_valid;
  logic [31:0]      fetch_npc;
  logic [31:0]      fetch_imemload;
  logic             doflush;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.PC_INIT(PC_INIT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .fetch_valid(fetch_valid),
    .fetch_npc(fetch_npc), .fetch_imemload(fetch_imemload), .doflush(doflush),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: where fetch is, whether it is waiting out a miss, whether it stopped
  logic [31:0] m_pc = PC_INIT;
  logic [31:0] m_pend = 32'd0;
  int unsigned m_cnt = 0;
  bit          m_drain = 1'b0;
  bit          m_stop = 1'b0;

  always @(posedge CLK) begin
    if (!nRST) begin
      m_pc = PC_INIT; m_pend = 32'd0; m_cnt = 0; m_drain = 1'b0; m_stop = 1'b0;
    end else if (!m_stop) begin
      if (halt) m_stop = 1'b1;
      else if (m_drain) begin
        if (redirect) m_pend = {redirect_pc[31:2], 2'b00};
        if (ihit) begin m_pc = m_pend; m_drain = 1'b0; end
      end else if (redirect) begin
        if (ihit) m_pc = {redirect_pc[31:2], 2'b00};
        else begin m_pend = {redirect_pc[31:2], 2'b00}; m_drain = 1'b1; end
      end else if (!stall && ihit) begin
        m_pc = m_pc + 32'd4;
        m_cnt++;
      end
    end
  end

  // Compare every cycle against the model
  always @(negedge CLK) begin
    if (!nRST) begin
      check("rst_ren", 32'(imemREN), 32'd0);
      check("rst_valid", 32'(fetch_valid), 32'd0);
      check("rst_flush", 32'(doflush), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
    end else begin
      check("m_count", fetch_count, m_cnt);
      check("m_halted", 32'(halted), 32'(m_stop));
      check("m_ren", 32'(imemREN), 32'(!m_stop));
      if (!m_stop) check("m_addr", imemaddr, m_pc);
      else         check("m_addr_frozen", imemaddr, m_pc);
      check("m_flush", 32'(doflush), 32'(!m_stop && !halt && redirect));
      check("m_valid", 32'(fetch_valid),
            32'(!m_stop && !m_drain && !halt && !redirect && !stall && ihit));
      if (fetch_valid) begin
        check("m_npc", fetch_npc, m_pc + 32'd4);
        check("m_load", fetch_imemload, imemload);
      end
    end
  end

  task automatic cyc(input logic r, input logic ih, input logic st, input logic rd,
                     input logic [31:0] rp, input logic hl);
    @(posedge CLK);
    #1;
    nRST = r; ihit = ih; stall = st; redirect = rd; redirect_pc = rp; halt = hl;
    imemload = $urandom;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("lit_rst_ren", 32'(imemREN), 32'd0);
    // Straight-line fetch
    cyc(1, 1, 0, 0, 0, 0);
    check("lit_a0", imemaddr, 32'h0); check("lit_n0", fetch_npc, 32'h4);
    check("lit_v0", 32'(fetch_valid), 32'd1);
    cyc(1, 1, 0, 0, 0, 0);
    check("lit_a1", imemaddr, 32'h4); check("lit_n1", fetch_npc, 32'h8);
    cyc(1, 1, 0, 0, 0, 0);
    check("lit_a2", imemaddr, 32'h8); check("lit_n2", fetch_npc, 32'hC);
    // Stall drops the hit
    cyc(1, 1, 1, 0, 0, 0);
    check("lit_cnt3", fetch_count, 32'd3); check("lit_st_a", imemaddr, 32'hC);
    check("lit_st_v", 32'(fetch_valid), 32'd0); check("lit_st_ren", 32'(imemREN), 32'd1);
    cyc(1, 1, 1, 0, 0, 0);
    check("lit_st_a2", imemaddr, 32'hC);
    cyc(1, 1, 0, 0, 0, 0);
    check("lit_rel_n", fetch_npc, 32'h10);
    // Redirect on a hit
    cyc(1, 1, 0, 1, 32'h40, 0);
    check("lit_rh_f", 32'(doflush), 32'd1); check("lit_rh_v", 32'(fetch_valid), 32'd0);
    // Redirect during a miss, then a second redirect while draining
    cyc(1, 0, 0, 1, 32'h80, 0);
    check("lit_rm_a", imemaddr, 32'h40); check("lit_rm_f", 32'(doflush), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      check("lit_dr_a", imemaddr, 32'h40);
    end
    cyc(1, 0, 0, 1, 32'hC0, 0);
    check("lit_dr_f", 32'(doflush), 32'd1);
    cyc(1, 1, 0, 0, 0, 0);
    check("lit_dr_disc", 32'(fetch_valid), 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    check("lit_dr_tgt", imemaddr, 32'hC0); check("lit_dr_cnt", fetch_count, 32'd4);
    // Drain: redirect with ihit same cycle, stall ignored, low bits dropped
    cyc(1, 0, 0, 1, 32'h100, 0);
    cyc(1, 1, 1, 1, 32'h143, 0);
    check("lit_dr2_f", 32'(doflush), 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    check("lit_dr2_a", imemaddr, 32'h140);
    // PC wrap
    cyc(1, 1, 0, 1, 32'hFFFF_FFFE, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check("lit_wr_a", imemaddr, 32'hFFFF_FFFC); check("lit_wr_n", fetch_npc, 32'h0);
    cyc(1, 1, 0, 0, 0, 0);
    check("lit_wr_a2", imemaddr, 32'h0); check("lit_wr_cnt", fetch_count, 32'd5);
    // Halt beats redirect and ihit
    cyc(1, 1, 0, 1, 32'h300, 1);
    check("lit_h_v", 32'(fetch_valid), 32'd0); check("lit_h_f", 32'(doflush), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 1, 32'h300, 0);
      check("lit_h_ren", 32'(imemREN), 32'd0); check("lit_h_hd", 32'(halted), 32'd1);
      check("lit_h_a", imemaddr, 32'h4); check("lit_h_cnt", fetch_count, 32'd6);
    end
    // Reset leaves HALTED
    cyc(0, 1, 0, 0, 0, 0);
    check("lit_r_hd", 32'(halted), 32'd0);
    cyc(1, 1, 0, 0, 0, 0);
    check("lit_r_a", imemaddr, PC_INIT); check("lit_r_cnt", fetch_count, 32'd0);
    cyc(1, 0, 0, 1, 32'h200, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("lit_rd_a", imemaddr, 32'h4);
    // Reset mid-drain loses the pending target
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("lit_rd_a2", imemaddr, PC_INIT); check("lit_rd_hd", 32'(halted), 32'd0);
    check("lit_rd_ren", 32'(imemREN), 32'd1);
    cyc(1, 1, 0, 0, 0, 0);
    check("lit_rd_n", fetch_npc, 32'h4); check("lit_rd_v", 32'(fetch_valid), 32'd1);
    // Halt while draining
    cyc(1, 0, 0, 1, 32'h500, 0);
    cyc(1, 1, 0, 0, 0, 1);
    check("lit_hd_v", 32'(fetch_valid), 32'd0);
    cyc(1, 1, 0, 0, 0, 0);
    check("lit_hd_hd", 32'(halted), 32'd1); check("lit_hd_a", imemaddr, 32'h4);
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
